// File: rtl/cmp_seq16.sv
// cmp_seq16: serial MSB-first magnitude comparator driving an external 4-bit comparator
//   clk, rst            : clock, synchronous active-high reset
//   start, ready        : compare request (taken only while ready is high in IDLE)
//   a_in, b_in          : operands, captured on accept
//   nib_a, nib_b        : current nibble pair sent to the external comparator
//   nib_eq/alb/agb      : flags returned by the external comparator
//   done                : one-cycle pulse when the result is valid
//   eq, alb, agb, err   : registered result; err marks flags that were not one-hot
//   nib_cnt             : number of nibbles examined in the last compare
module cmp_seq16 #(
   parameter int N_NIB = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [4*N_NIB-1:0]       a_in,
   input  logic [4*N_NIB-1:0]       b_in,
   output logic                     ready,
   output logic [3:0]               nib_a,
   output logic [3:0]               nib_b,
   input  logic                     nib_eq,
   input  logic                     nib_alb,
   input  logic                     nib_agb,
   output logic                     done,
   output logic                     eq,
   output logic                     alb,
   output logic                     agb,
   output logic                     err,
   output logic [$clog2(N_NIB):0]   nib_cnt
);
   localparam int W  = 4 * N_NIB;
   localparam int IW = $clog2(N_NIB);
   localparam int CW = IW + 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(N_NIB - 1);
   typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;
   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, a_sh, b_sh;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          eq_q, eq_d, alb_q, alb_d, agb_q, agb_d, err_q, err_d;
   logic [2:0]    flags;
   logic          hit_eq, onehot;
   assign flags  = {nib_eq, nib_alb, nib_agb};
   assign hit_eq = flags == 3'b100;
   assign onehot = hit_eq || flags == 3'b010 || flags == 3'b001;
   assign a_sh   = a_q >> {idx_q, 2'b00};
   assign b_sh   = b_q >> {idx_q, 2'b00};
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end
   // Only an equal nibble with lower nibbles still pending keeps the compare going.
   always_comb begin
      state_d = (state_q == S_IDLE) ? (start ? S_CMP : S_IDLE)
              : (state_q == S_CMP)  ? ((hit_eq && idx_q != '0) ? S_CMP : S_DONE)
              : S_IDLE;
   end
   always_comb begin
      ready = state_q == S_IDLE;
      done  = state_q == S_DONE;
      nib_a = (state_q == S_CMP) ? a_sh[3:0] : 4'h0;
      nib_b = (state_q == S_CMP) ? b_sh[3:0] : 4'h0;
   end
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      eq_d  = eq_q;
      alb_d = alb_q;
      agb_d = agb_q;
      err_d = err_q;
      if (state_q == S_IDLE && start) begin
         a_d   = a_in;
         b_d   = b_in;
         idx_d = IDX_TOP;
         cnt_d = '0;
         eq_d  = 1'b0;
         alb_d = 1'b0;
         agb_d = 1'b0;
         err_d = 1'b0;
      end else if (state_q == S_CMP) begin
         cnt_d = cnt_q + 1'b1;
         idx_d = (idx_q != '0) ? idx_q - 1'b1 : idx_q;
         eq_d  = hit_eq && idx_q == '0;
         alb_d = flags == 3'b010;
         agb_d = flags == 3'b001;
         err_d = !onehot;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         eq_q  <= 1'b0;
         alb_q <= 1'b0;
         agb_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         eq_q  <= eq_d;
         alb_q <= alb_d;
         agb_q <= agb_d;
         err_q <= err_d;
      end
   end
   assign eq      = eq_q;
   assign alb     = alb_q;
   assign agb     = agb_q;
   assign err     = err_q;
   assign nib_cnt = cnt_q;
endmodule
